// File: rtl/fpm_arbiter.sv
// Round-robin arbiter sharing one combinational fpm multiplier between two
// valid/ready requesters, one transaction in flight, product held until accepted.
module fpm_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [1:0]        req_aadd,
  input  logic [1:0]        req_badd,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_add,
  output logic [DATA_W-1:0] mul_in1,
  output logic [DATA_W-1:0] mul_in2,
  output logic              mul_add1,
  output logic              mul_add2,
  input  logic [DATA_W-1:0] mul_out,
  input  logic              mul_addout,
  output logic              grant_id,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]       LAT_INIT = 4'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr;
  logic                r_grant;
  logic [3:0]          r_cnt;
  logic [CNT_W-1:0]    r_ops;
  logic [DATA_W-1:0]   r_mul_in1;
  logic [DATA_W-1:0]   r_mul_in2;
  logic                r_mul_add1;
  logic                r_mul_add2;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_add;

  logic                w_gnt_vld;
  logic                w_gnt;
  logic                w_accept;
  logic                w_rsp_hs;
  logic [1:0]          w_req_ready;
  logic [1:0]          w_rsp_valid;
  logic [DATA_W-1:0]   w_op_a;
  logic [DATA_W-1:0]   w_op_b;
  logic                w_op_aadd;
  logic                w_op_badd;

  // Round-robin grant candidate: rr has priority, otherwise the other requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_rr;
    if (req_valid[r_rr]) begin
      w_gnt_vld = 1'b1;
      w_gnt     = r_rr;
    end else if (req_valid[~r_rr]) begin
      w_gnt_vld = 1'b1;
      w_gnt     = ~r_rr;
    end else begin
      w_gnt_vld = 1'b0;
      w_gnt     = r_rr;
    end
  end

  // Request accept and response valid decode; req_ready held low during reset.
  always_comb begin
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    if (rst_n && (r_state == ST_IDLE) && w_gnt_vld) begin
      w_req_ready[w_gnt] = 1'b1;
    end else begin
      w_req_ready = 2'b00;
    end
    if (r_state == ST_RESP) begin
      w_rsp_valid[r_grant] = 1'b1;
    end else begin
      w_rsp_valid = 2'b00;
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_gnt_vld;
  // Only the owner's rsp_ready can complete the response.
  assign w_rsp_hs  = (r_state == ST_RESP) && rsp_ready[r_grant];
  assign w_op_a    = w_gnt ? req_a1 : req_a0;
  assign w_op_b    = w_gnt ? req_b1 : req_b0;
  assign w_op_aadd = req_aadd[w_gnt];
  assign w_op_badd = req_badd[w_gnt];

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, latency counter, product capture and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= 1'b0;
      r_grant    <= 1'b0;
      r_cnt      <= 4'd0;
      r_ops      <= {CNT_W{1'b0}};
      r_mul_in1  <= {DATA_W{1'b0}};
      r_mul_in2  <= {DATA_W{1'b0}};
      r_mul_add1 <= 1'b0;
      r_mul_add2 <= 1'b0;
      r_rsp_data <= {DATA_W{1'b0}};
      r_rsp_add  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mul_in1  <= w_op_a;
        r_mul_in2  <= w_op_b;
        r_mul_add1 <= w_op_aadd;
        r_mul_add2 <= w_op_badd;
        r_grant    <= w_gnt;
        r_cnt      <= LAT_INIT;
      end
      if (r_state == ST_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_rsp_data <= mul_out;
          r_rsp_add  <= mul_addout;
        end
      end
      if (w_rsp_hs) begin
        r_rr  <= ~r_grant;
        r_ops <= r_ops + CNT_ONE;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_add   = r_rsp_add;
  assign mul_in1   = r_mul_in1;
  assign mul_in2   = r_mul_in2;
  assign mul_add1  = r_mul_add1;
  assign mul_add2  = r_mul_add2;
  assign grant_id  = r_grant;
  assign busy      = (r_state != ST_IDLE);
  assign ops_done  = r_ops;

endmodule

// File: tb/tb_fpm_arbiter.sv
// Directed bench for fpm_arbiter: a behavioural fpm sits on the mul_* ports of
// a MUL_LAT=1 instance and a MUL_LAT=3 / CNT_W=2 instance.
module tb_fpm_arbiter;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_errors;

  logic [1:0]  req_valid, req_ready, req_aadd, req_badd, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1, rsp_data, mul_in1, mul_in2, mul_out;
  logic        rsp_add, mul_add1, mul_add2, mul_addout, grant_id, busy;
  logic [15:0] ops_done;

  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_data, b_mul_in1, b_mul_in2, b_mul_out;
  logic        b_rsp_add, b_mul_add1, b_mul_add2, b_mul_addout, b_grant_id, b_busy;
  logic [1:0]  b_ops_done;

  // Behavioural fpm for normal operands: zero if either hidden bit is clear.
  function automatic logic [32:0] fpm_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic aa, input logic ab);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    if (!(aa && ab)) return 33'd0;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      f = m[46:24];
    end else begin
      f = m[45:23];
    end
    return {1'b1, a[31] ^ b[31], e[7:0], f};
  endfunction

  assign {mul_addout, mul_out}     = fpm_model(mul_in1, mul_in2, mul_add1, mul_add2);
  assign {b_mul_addout, b_mul_out} = fpm_model(b_mul_in1, b_mul_in2, b_mul_add1, b_mul_add2);

  fpm_arbiter #(.DATA_W(32), .MUL_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_aadd(req_aadd), .req_badd(req_badd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_add(rsp_add),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_add1(mul_add1), .mul_add2(mul_add2),
    .mul_out(mul_out), .mul_addout(mul_addout),
    .grant_id(grant_id), .busy(busy), .ops_done(ops_done)
  );

  fpm_arbiter #(.DATA_W(32), .MUL_LAT(3), .CNT_W(2)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a0(32'h4040_0000), .req_a1(32'h0000_0000), .req_b0(32'h4040_0000), .req_b1(32'h0000_0000),
    .req_aadd(2'b11), .req_badd(2'b11),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_add(b_rsp_add),
    .mul_in1(b_mul_in1), .mul_in2(b_mul_in2), .mul_add1(b_mul_add1), .mul_add2(b_mul_add2),
    .mul_out(b_mul_out), .mul_addout(b_mul_addout),
    .grant_id(b_grant_id), .busy(b_busy), .ops_done(b_ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from accept until the first edge that samples rsp_valid high.
  task automatic wait_resp(output int lat);
    int n;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic wait_resp_b(output int lat);
    int n;
    n = 0;
    while (b_rsp_valid == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; req_aadd = 2'b11; req_badd = 2'b11;
    req_a0 = 32'h0; req_a1 = 32'h0; req_b0 = 32'h0; req_b1 = 32'h0;
    b_req_valid = 2'b00; b_rsp_ready = 2'b00;

    // Reset values, req_ready forced low even with requests pending
    #2 req_valid = 2'b11;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_ops_done", 64'(ops_done), 64'h0);
    check("rst_mul_in1", 64'(mul_in1), 64'h0);
    check("rst_rsp_data", 64'(rsp_data), 64'h0);
    check("rst_grant_id", 64'(grant_id), 64'h0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single request from requester 0, 2.0 * 3.0
    req_a0 = 32'h4000_0000; req_b0 = 32'h4040_0000; req_valid = 2'b01;
    #1 check("t1_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_mul_in2", 64'(mul_in2), 64'h4040_0000);
    wait_resp(lat);
    check("t1_latency", 64'(lat), 64'd2);
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_data", 64'(rsp_data), 64'h40C0_0000);
    check("t1_rsp_add", 64'(rsp_add), 64'h1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("t1_ops_done", 64'(ops_done), 64'd1);
    check("t1_idle", 64'(busy), 64'h0);

    // 2: both valid after reset, 0 first then 1
    do_reset();
    req_a0 = 32'h4000_0000; req_b0 = 32'h4000_0000;
    req_a1 = 32'h3FC0_0000; req_b1 = 32'h3FC0_0000;
    req_valid = 2'b11;
    #1 check("t2_req_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    check("t2_grant0", 64'(grant_id), 64'h0);
    check("t2_wait_ready", 64'(req_ready), 64'h0);
    wait_resp(lat);
    check("t2_rsp_valid0", 64'(rsp_valid), 64'h1);
    check("t2_rsp_data0", 64'(rsp_data), 64'h4080_0000);
    rsp_ready = 2'b11;
    tick();
    check("t2_req_ready1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    check("t2_grant1", 64'(grant_id), 64'h1);
    wait_resp(lat);
    check("t2_rsp_valid1", 64'(rsp_valid), 64'h2);
    check("t2_rsp_data1", 64'(rsp_data), 64'h4010_0000);
    tick();
    rsp_ready = 2'b00;
    check("t2_ops_done", 64'(ops_done), 64'd2);

    // 3: back-pressure; the non-owner's rsp_ready must be ignored
    req_a0 = 32'h3F80_0000; req_b0 = 32'h40A0_0000; req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      check("t3_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t3_rsp_data", 64'(rsp_data), 64'h40A0_0000);
      check("t3_req_ready", 64'(req_ready), 64'h0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("t3_ops_done", 64'(ops_done), 64'd3);

    // 4: hidden bit of operand 1 clear on requester 1 gives zero
    req_a1 = 32'h4000_0000; req_b1 = 32'h4040_0000; req_aadd = 2'b01; req_valid = 2'b10;
    #1 check("t4_req_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    wait_resp(lat);
    check("t4_rsp_valid", 64'(rsp_valid), 64'h2);
    check("t4_rsp_data", 64'(rsp_data), 64'h0);
    check("t4_rsp_add", 64'(rsp_add), 64'h0);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    req_aadd = 2'b11;
    check("t4_ops_done", 64'(ops_done), 64'd4);
    check("t4_idle", 64'(busy), 64'h0);

    // 5: reset during WAIT aborts the transaction
    req_a0 = 32'h4000_0000; req_b0 = 32'h4040_0000; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("t5_in_wait", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("t5_rst_busy", 64'(busy), 64'h0);
    check("t5_rst_ops_done", 64'(ops_done), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_no_rsp", 64'(rsp_valid), 64'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(lat);
    check("t5_latency", 64'(lat), 64'd2);
    check("t5_rsp_data", 64'(rsp_data), 64'h40C0_0000);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("t5_ops_done", 64'(ops_done), 64'd1);

    // 6: MUL_LAT=3, CNT_W=2 instance, 3.0 * 3.0, counter wraps after 4
    for (int i = 0; i < 4; i++) begin
      b_req_valid = 2'b01;
      #1 check("t6_req_ready", 64'(b_req_ready), 64'h1);
      tick();
      b_req_valid = 2'b00;
      wait_resp_b(lat);
      check("t6_latency", 64'(lat), 64'd4);
      check("t6_rsp_data", 64'(b_rsp_data), 64'h4110_0000);
      b_rsp_ready = 2'b01;
      tick();
      b_rsp_ready = 2'b00;
      check("t6_ops_done", 64'(b_ops_done), 64'((i + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
